// File: rtl/entropy_sequencer.sv
// Frame/MCU sequencer in front of the JPEG entropy coder: registers the coefficient-pair
// stream and generates the pair index, component select and last-MCU sideband.
module entropy_sequencer #(
    parameter int Y_BLOCKS = 4,
    parameter int MCU_W    = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    frame_start,
    input  logic                    frame_abort,
    input  logic [MCU_W-1:0]        mcu_total,
    input  logic signed [1:0][10:0] in_q,
    input  logic                    in_valid,
    output logic                    in_hold,
    output logic signed [1:0][10:0] q,
    output logic                    q_valid,
    input  logic                    q_hold,
    output logic [4:0]              q_cnt,
    output logic [1:0]              q_chroma,
    output logic                    q_last_mcu,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    start_err
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    localparam logic [2:0]       BLK_CB   = 3'(Y_BLOCKS);
    localparam logic [2:0]       BLK_LAST = 3'(Y_BLOCKS + 1);
    localparam logic [MCU_W-1:0] MCU_ONE  = {{(MCU_W-1){1'b0}}, 1'b1};

    state_t                  state_q, state_d;
    logic [4:0]              pair_q, pair_d;
    logic [2:0]              blk_q, blk_d;
    logic [MCU_W-1:0]        mcu_q, mcu_d;
    logic [MCU_W-1:0]        total_q, total_d;
    logic [MCU_W-1:0]        total_m1;
    logic signed [1:0][10:0] data_q, data_d;
    logic                    valid_q, valid_d;
    logic [4:0]              cnt_q, cnt_d;
    logic [1:0]              chroma_q, chroma_d;
    logic                    last_q, last_d;
    logic                    start_err_q, start_err_d;
    logic                    frame_done_q, frame_done_d;

    logic in_xfer;
    logic out_xfer;
    logic load_en;
    logic start_ok;
    logic pair_wrap;
    logic blk_wrap;
    logic last_pair;

    assign total_m1  = total_q - MCU_ONE;
    assign load_en   = !valid_q || !q_hold;
    assign in_xfer   = in_valid && !in_hold;
    assign out_xfer  = valid_q && !q_hold;
    assign start_ok  = frame_start && !frame_abort && (state_q == IDLE) && (mcu_total != '0);
    assign pair_wrap = (pair_q == 5'd31);
    assign blk_wrap  = (blk_q == BLK_LAST);
    assign last_pair = pair_wrap && blk_wrap && (mcu_q == total_m1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_ok) state_d = RUN;
            RUN:     if (in_xfer && last_pair) state_d = FLUSH;
            FLUSH:   if (out_xfer) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (frame_abort) state_d = IDLE;
    end

    always_comb begin
        busy    = (state_q != IDLE);
        in_hold = (state_q != RUN) || (valid_q && q_hold);
    end

    always_comb begin
        pair_d       = pair_q;
        blk_d        = blk_q;
        mcu_d        = mcu_q;
        total_d      = total_q;
        data_d       = data_q;
        valid_d      = valid_q;
        cnt_d        = cnt_q;
        chroma_d     = chroma_q;
        last_d       = last_q;
        start_err_d  = start_err_q;
        frame_done_d = 1'b0;

        if (frame_start && !frame_abort) begin
            if (start_ok) begin
                start_err_d = 1'b0;
                total_d     = mcu_total;
                pair_d      = '0;
                blk_d       = '0;
                mcu_d       = '0;
            end else begin
                start_err_d = 1'b1;
            end
        end

        // Counters advance on accepted input; the final pair leaves them cleared for the next frame.
        if (in_xfer) begin
            if (last_pair) begin
                pair_d = '0;
                blk_d  = '0;
                mcu_d  = '0;
            end else begin
                pair_d = pair_q + 5'd1;
                if (pair_wrap) begin
                    if (blk_wrap) begin
                        blk_d = '0;
                        mcu_d = mcu_q + MCU_ONE;
                    end else begin
                        blk_d = blk_q + 3'd1;
                    end
                end
            end
        end

        if (load_en) begin
            valid_d = in_xfer;
            if (in_xfer) begin
                data_d   = in_q;
                cnt_d    = pair_q;
                chroma_d = (blk_q < BLK_CB) ? 2'd0 : ((blk_q == BLK_CB) ? 2'd1 : 2'd2);
                last_d   = (mcu_q == total_m1);
            end
        end

        if ((state_q == FLUSH) && out_xfer && !frame_abort) frame_done_d = 1'b1;

        if (frame_abort) begin
            valid_d = 1'b0;
            pair_d  = '0;
            blk_d   = '0;
            mcu_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pair_q       <= '0;
            blk_q        <= '0;
            mcu_q        <= '0;
            total_q      <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            cnt_q        <= '0;
            chroma_q     <= '0;
            last_q       <= 1'b0;
            start_err_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            pair_q       <= pair_d;
            blk_q        <= blk_d;
            mcu_q        <= mcu_d;
            total_q      <= total_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            cnt_q        <= cnt_d;
            chroma_q     <= chroma_d;
            last_q       <= last_d;
            start_err_q  <= start_err_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign q          = data_q;
    assign q_valid    = valid_q;
    assign q_cnt      = cnt_q;
    assign q_chroma   = chroma_q;
    assign q_last_mcu = last_q;
    assign frame_done = frame_done_q;
    assign start_err  = start_err_q;

endmodule

// File: tb/tb_entropy_sequencer.sv
// Directed testbench for entropy_sequencer: a 4:2:0 instance for most scenarios and a
// 4:4:4 instance for the single-MCU frame; outputs are scored against a per-pair model.
module tb_entropy_sequencer;

    localparam int MCU_W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    resetn;
    logic                    frame_start;
    logic                    frame_abort;
    logic [MCU_W-1:0]        mcu_total;
    logic signed [1:0][10:0] in_q;
    logic                    in_valid;
    logic                    q_hold;

    logic                    in_hold_a, q_valid_a, last_a, busy_a, done_a, err_a;
    logic signed [1:0][10:0] q_a;
    logic [4:0]              cnt_a;
    logic [1:0]              chroma_a;

    logic                    in_hold_b, q_valid_b, last_b, busy_b, done_b, err_b;
    logic signed [1:0][10:0] q_b;
    logic [4:0]              cnt_b;
    logic [1:0]              chroma_b;

    entropy_sequencer #(.Y_BLOCKS(4), .MCU_W(MCU_W)) dut_a (
        .clk(clk), .resetn(resetn), .frame_start(frame_start), .frame_abort(frame_abort),
        .mcu_total(mcu_total), .in_q(in_q), .in_valid(in_valid), .in_hold(in_hold_a),
        .q(q_a), .q_valid(q_valid_a), .q_hold(q_hold), .q_cnt(cnt_a), .q_chroma(chroma_a),
        .q_last_mcu(last_a), .busy(busy_a), .frame_done(done_a), .start_err(err_a)
    );

    entropy_sequencer #(.Y_BLOCKS(1), .MCU_W(MCU_W)) dut_b (
        .clk(clk), .resetn(resetn), .frame_start(frame_start), .frame_abort(frame_abort),
        .mcu_total(mcu_total), .in_q(in_q), .in_valid(in_valid), .in_hold(in_hold_b),
        .q(q_b), .q_valid(q_valid_b), .q_hold(q_hold), .q_cnt(cnt_b), .q_chroma(chroma_b),
        .q_last_mcu(last_b), .busy(busy_b), .frame_done(done_b), .start_err(err_b)
    );

    int checks = 0;
    int fails = 0;
    bit use_b = 1'b0;
    int yb = 4;
    int total = 0;
    int pairs = 0;
    int n_in = 0;
    int n_out = 0;
    int done_seen = 0;
    bit active = 1'b0;

    logic        s_in_hold, s_q_valid, s_done, s_busy;
    logic [29:0] s_vec;

    always_comb begin
        if (use_b) begin
            s_in_hold = in_hold_b;
            s_q_valid = q_valid_b;
            s_done    = done_b;
            s_busy    = busy_b;
            s_vec     = {q_b, cnt_b, chroma_b, last_b};
        end else begin
            s_in_hold = in_hold_a;
            s_q_valid = q_valid_a;
            s_done    = done_a;
            s_busy    = busy_a;
            s_vec     = {q_a, cnt_a, chroma_a, last_a};
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [21:0] mk_data(input int n);
        logic [10:0] lo;
        lo = 11'(n);
        return {lo ^ 11'h5A3, lo};
    endfunction

    // Expected {q, q_cnt, q_chroma, q_last_mcu} for the n-th pair of the current frame.
    function automatic logic [29:0] exp_vec(input int n);
        int blk;
        int mcu;
        logic [1:0] ch;
        blk = (n / 32) % (yb + 2);
        mcu = n / (32 * (yb + 2));
        ch  = (blk < yb) ? 2'd0 : ((blk == yb) ? 2'd1 : 2'd2);
        return {mk_data(n), 5'(n % 32), ch, 1'(mcu == total - 1)};
    endfunction

    task automatic applyStimulus(input logic iv, input logic qh);
        logic in_acc;
        logic out_acc;
        logic exp_done;
        in_valid = iv;
        q_hold   = qh;
        in_q     = mk_data(n_in);
        #1;
        in_acc   = in_valid && !s_in_hold;
        out_acc  = s_q_valid && !q_hold;
        exp_done = 1'b0;
        if (active && s_q_valid) checkOutput("q_pair", 32'(s_vec), 32'(exp_vec(n_out)));
        if (active && out_acc) begin
            n_out++;
            if (n_out == pairs && !frame_abort) begin
                exp_done = 1'b1;
                active   = 1'b0;
            end
        end
        if (in_acc) n_in++;
        if (frame_abort) active = 1'b0;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        frame_abort = 1'b0;
        checkOutput("frame_done", 32'(s_done), 32'(exp_done));
        if (s_done) done_seen++;
    endtask

    task automatic startFrame(input int tot);
        total     = tot;
        pairs     = 32 * (yb + 2) * tot;
        n_in      = 0;
        n_out     = 0;
        done_seen = 0;
        active    = 1'b1;
        frame_start = 1'b1;
        mcu_total   = MCU_W'(tot);
        applyStimulus(1'b1, 1'b0);
    endtask

    task automatic runFrame(input int budget, input bit rnd, input int poke_at);
        for (int i = 0; i < budget && active; i++) begin
            if (i == poke_at) begin
                frame_start = 1'b1;
                mcu_total   = 16'd5;
            end
            if (rnd) applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4);
            else     applyStimulus(1'b1, 1'b0);
            if (i == poke_at) begin
                checkOutput("start_err_midframe", 32'(err_a), 32'd1);
                checkOutput("busy_midframe", 32'(busy_a), 32'd1);
            end
        end
        checkOutput("frame_timeout", 32'(active), 32'd0);
    endtask

    initial begin
        resetn      = 1'b0;
        frame_start = 1'b0;
        frame_abort = 1'b0;
        mcu_total   = '0;
        in_q        = '0;
        in_valid    = 1'b1;
        q_hold      = 1'b0;

        // Reset with in_valid high: nothing may be accepted before a frame starts.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_hold", 32'(in_hold_a), 32'd1);
        checkOutput("rst_q_valid", 32'(q_valid_a), 32'd0);
        checkOutput("rst_busy", 32'(busy_a), 32'd0);
        checkOutput("rst_start_err", 32'(err_a), 32'd0);
        checkOutput("rst_frame_done", 32'(done_a), 32'd0);
        checkOutput("rst_q_cnt", 32'(cnt_a), 32'd0);
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput("idle_q_valid", 32'(q_valid_a), 32'd0);
            checkOutput("idle_in_hold", 32'(in_hold_a), 32'd1);
        end

        // Two-MCU 4:2:0 frame at full rate.
        startFrame(2);
        checkOutput("busy_after_start", 32'(busy_a), 32'd1);
        runFrame(500, 1'b0, -1);
        checkOutput("f2_pairs_out", 32'(n_out), 32'd384);
        checkOutput("f2_done_count", 32'(done_seen), 32'd1);
        checkOutput("f2_busy_end", 32'(busy_a), 32'd0);
        checkOutput("f2_q_valid_end", 32'(q_valid_a), 32'd0);

        // Three-MCU frame with random throttling on both sides and a stray mid-frame start.
        startFrame(3);
        runFrame(10000, 1'b1, 100);
        checkOutput("f3_pairs_out", 32'(n_out), 32'd576);
        checkOutput("f3_done_count", 32'(done_seen), 32'd1);
        checkOutput("f3_start_err_sticky", 32'(err_a), 32'd1);

        // Valid start clears start_err; abort at MCU 1 pair 17 while stalled.
        startFrame(2);
        checkOutput("start_err_cleared", 32'(err_a), 32'd0);
        for (int i = 0; i < 500 && n_out < 209; i++) applyStimulus(1'b1, 1'b0);
        checkOutput("abort_pos_n_out", 32'(n_out), 32'd209);
        checkOutput("abort_pos_q_cnt", 32'(cnt_a), 32'd17);
        frame_abort = 1'b1;
        applyStimulus(1'b1, 1'b1);
        checkOutput("abort_q_valid", 32'(q_valid_a), 32'd0);
        checkOutput("abort_busy", 32'(busy_a), 32'd0);
        checkOutput("abort_in_hold", 32'(in_hold_a), 32'd1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("abort_idle_busy", 32'(busy_a), 32'd0);
        startFrame(1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("restart_q_valid", 32'(q_valid_a), 32'd1);
        checkOutput("restart_q_cnt", 32'(cnt_a), 32'd0);
        checkOutput("restart_q_chroma", 32'(chroma_a), 32'd0);
        runFrame(500, 1'b0, -1);
        checkOutput("f1_pairs_out", 32'(n_out), 32'd192);

        // Zero-length frame request is rejected.
        frame_start = 1'b1;
        mcu_total   = '0;
        applyStimulus(1'b1, 1'b0);
        checkOutput("zero_total_err", 32'(err_a), 32'd1);
        checkOutput("zero_total_busy", 32'(busy_a), 32'd0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("zero_total_idle", 32'(busy_a), 32'd0);

        // Single-MCU 4:4:4 frame on the second instance.
        resetn = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("b_rst_in_hold", 32'(in_hold_b), 32'd1);
        resetn = 1'b1;
        use_b  = 1'b1;
        yb     = 1;
        startFrame(1);
        runFrame(300, 1'b0, -1);
        checkOutput("b_pairs_out", 32'(n_out), 32'd96);
        checkOutput("b_done_count", 32'(done_seen), 32'd1);
        checkOutput("b_busy_end", 32'(s_busy), 32'd0);
        frame_abort = 1'b1;
        applyStimulus(1'b0, 1'b0);
        checkOutput("a_abort_busy", 32'(busy_a), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
